load_store_unit: RTL and testbench

//  Multi-cycle load/store engine between execute and the register-file write port.
//  - Accepts one memory op from execute and drives a word-addressed data-memory req/ready/rvalid interface.
//  - For loads: aligns and sign/zero-extends the read data, then issues a one-cycle writeback (wb_en/wb_rd/wb_data).
//  - Holds busy high so the core stalls while an op is in flight.

---
 rtl/load_store_unit.sv | 195 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Multi-cycle load/store engine: takes one memory op from execute, runs the
// word-addressed data-memory handshake and returns extended load data to the register file.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_is_store,
    input  logic [2:0]  op_funct3,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    input  logic [4:0]  op_rd,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err_valid,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_R,
        WB,
        ERR
    } state_t;

    // The op owns the memory for TIMEOUT_CYCLES cycles in REQ+WAIT_R, counted from 0.
    localparam logic [7:0] LAST_CYCLE = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        illegal;
    logic        misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;
    logic [3:0]  st_strb;
    logic [31:0] st_data;

    always_comb begin
        illegal    = op_is_store ? (op_funct3 > 3'b010)
                                 : (op_funct3 == 3'b011 || op_funct3[2:1] == 2'b11);
        misaligned = (op_funct3[1:0] == 2'b01 && op_addr[0])
                  || (op_funct3[1:0] == 2'b10 && op_addr[1:0] != 2'b00);
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_ext = {24'b0, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_ext = {16'b0, ld_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Store data is replicated across lanes so memory only needs the strobes.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                st_strb = 4'b0001 << addr_q[1:0];
                st_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << addr_q[1:0];
                st_data = {2{wdata_q[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        data_d     = data_q;
        err_code_d = err_code_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    is_store_d = op_is_store;
                    funct3_d   = op_funct3;
                    addr_d     = op_addr;
                    wdata_d    = op_wdata;
                    rd_d       = op_rd;
                    cnt_d      = 8'd0;
                    if (illegal) begin
                        err_code_d = 2'b10;
                        state_d    = ERR;
                    end else if (misaligned) begin
                        err_code_d = 2'b01;
                        state_d    = ERR;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_ready) begin
                    state_d = is_store_q ? IDLE : WAIT_R;
                end else if (cnt_q == LAST_CYCLE) begin
                    err_code_d = 2'b11;
                    state_d    = ERR;
                end
            end
            WAIT_R: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_rvalid) begin
                    data_d  = load_ext;
                    state_d = WB;
                end else if (cnt_q == LAST_CYCLE) begin
                    err_code_d = 2'b11;
                    state_d    = ERR;
                end
            end
            WB:      state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rd_q       <= 5'd0;
            data_q     <= 32'd0;
            err_code_q <= 2'b00;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            err_code_q <= err_code_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs are gated by state so idle values stay zero after an op completes.
    assign op_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req && is_store_q;
    assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wdata = mem_we ? st_data : 32'd0;
    assign mem_wstrb = mem_we ? st_strb : 4'b0000;
    assign wb_en     = (state_q == WB) && (rd_q != 5'd0);
    assign wb_rd     = (state_q == WB) ? rd_q : 5'd0;
    assign wb_data   = (state_q == WB) ? data_q : 32'd0;
    assign err_valid = (state_q == ERR);
    assign err_code  = err_valid ? err_code_q : 2'b00;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected results are queued when an op is
// issued and compared once the op has run against a small memory responder.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic        op_is_store;
    logic [2:0]  op_funct3;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [4:0]  op_rd;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err_valid;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_is_store(op_is_store), .op_funct3(op_funct3), .op_addr(op_addr),
        .op_wdata(op_wdata), .op_rd(op_rd), .busy(busy), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .err_valid(err_valid), .err_code(err_code)
    );

    typedef struct {
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        is_err;
        logic [1:0]  code;
        logic [3:0]  strb;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    int          obs_wb_cnt, obs_wb_cycle, obs_err_cnt, obs_err_cycle;
    int          obs_req_cnt, obs_idle_cycle, obs_ready_bad;
    logic        obs_ready_offer, obs_we;
    logic [4:0]  obs_wb_rd;
    logic [31:0] obs_wb_data, obs_addr, obs_wdata;
    logic [3:0]  obs_strb;
    logic [1:0]  obs_code;

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] w);
        logic [31:0] s;
        s = w >> (int'(lane) * 8);
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    // Offers one op at a negedge, then plays memory for ncyc cycles: mem_ready after
    // ready_delay request cycles, read data the cycle after that.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, input int ready_delay,
                          input logic [31:0] rdata, input int ncyc);
        int req_seen;
        logic rv_next;
        obs_wb_cnt = 0; obs_wb_cycle = -1; obs_err_cnt = 0; obs_err_cycle = -1;
        obs_req_cnt = 0; obs_idle_cycle = -1; obs_ready_bad = 0;
        obs_we = 1'b0; obs_wb_rd = '0; obs_wb_data = '0; obs_addr = '0; obs_wdata = '0;
        obs_strb = '0; obs_code = '0;
        op_valid = 1'b1; op_is_store = st; op_funct3 = f3; op_addr = addr;
        op_wdata = wdata; op_rd = rd;
        obs_ready_offer = op_ready;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        req_seen = 0;
        rv_next = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            if (wb_en) begin
                obs_wb_cnt++;
                if (obs_wb_cycle < 0) begin
                    obs_wb_cycle = k; obs_wb_rd = wb_rd; obs_wb_data = wb_data;
                end
            end
            if (err_valid) begin
                obs_err_cnt++;
                if (obs_err_cycle < 0) begin
                    obs_err_cycle = k; obs_code = err_code;
                end
            end
            if (mem_req) begin
                obs_req_cnt++;
                obs_addr = mem_addr; obs_wdata = mem_wdata; obs_strb = mem_wstrb; obs_we = mem_we;
            end
            if (op_ready && obs_idle_cycle < 0) obs_idle_cycle = k;
            if (op_ready !== !busy) obs_ready_bad++;
            mem_rvalid = rv_next;
            mem_rdata  = rv_next ? rdata : $urandom;
            mem_ready  = mem_req && (req_seen == ready_delay);
            rv_next    = mem_ready && !st;
            if (mem_req) req_seen++;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL reset_op_ready: got %b want 1", op_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if ({wb_en, err_valid} !== 2'b00) begin failures++; $display("FAIL reset_pulses: got %b want 00", {wb_en, err_valid}); end
        checks++; if ({mem_addr, mem_wdata, mem_wstrb, wb_data} !== '0) begin failures++; $display("FAIL reset_data_zero: got nonzero %h", {mem_addr, mem_wdata, mem_wstrb, wb_data}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lw();
        exp_t e;
        sb.push_back('{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 2'b00, 4'b0000, 32'h100});
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF, 6);
        e = sb.pop_front();
        checks++; if (obs_req_cnt !== 1) begin failures++; $display("FAIL lw_req_cycles: got %0d want 1", obs_req_cnt); end
        checks++; if (obs_addr !== e.addr) begin failures++; $display("FAIL lw_mem_addr: got %h want %h", obs_addr, e.addr); end
        checks++; if ({obs_we, obs_strb} !== 5'b0) begin failures++; $display("FAIL lw_we_strb: got %b want 00000", {obs_we, obs_strb}); end
        checks++; if (obs_wb_cycle !== 3) begin failures++; $display("FAIL lw_wb_latency: got %0d want 3", obs_wb_cycle); end
        checks++; if (obs_wb_cnt !== 1) begin failures++; $display("FAIL lw_wb_pulses: got %0d want 1", obs_wb_cnt); end
        checks++; if (obs_wb_rd !== e.rd) begin failures++; $display("FAIL lw_wb_rd: got %0d want %0d", obs_wb_rd, e.rd); end
        checks++; if (obs_wb_data !== e.data) begin failures++; $display("FAIL lw_wb_data: got %h want %h", obs_wb_data, e.data); end
        checks++; if (obs_err_cnt !== 0) begin failures++; $display("FAIL lw_no_err: got %0d want 0", obs_err_cnt); end
        checks++; if (obs_ready_bad !== 0) begin failures++; $display("FAIL lw_busy_ready: got %0d bad cycles want 0", obs_ready_bad); end
    endtask

    task automatic test_load_ext();
        exp_t e;
        logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0] f3;
        logic [31:0] a, rdata;
        logic [4:0] rd;
        int dly;
        sb.push_back('{1'b1, 5'd7, 32'hFFFFFF80, 1'b0, 2'b00, 4'b0000, 32'h100});
        run_op(1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 0, 32'h80FF0000, 6);
        e = sb.pop_front();
        checks++; if (obs_wb_data !== e.data) begin failures++; $display("FAIL lb_sign: got %h want %h", obs_wb_data, e.data); end
        sb.push_back('{1'b1, 5'd8, 32'h00000080, 1'b0, 2'b00, 4'b0000, 32'h100});
        run_op(1'b0, 3'b100, 32'h103, 32'h0, 5'd8, 0, 32'h80FF0000, 6);
        e = sb.pop_front();
        checks++; if (obs_wb_data !== e.data) begin failures++; $display("FAIL lbu_zero: got %h want %h", obs_wb_data, e.data); end
        for (int i = 0; i < 10; i++) begin
            f3 = f3s[$urandom_range(0, 4)];
            a = $urandom;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            rdata = $urandom;
            rd = 5'($urandom_range(1, 31));
            dly = $urandom_range(0, 1);
            sb.push_back('{1'b1, rd, model_load(f3, a[1:0], rdata), 1'b0, 2'b00, 4'b0000, {a[31:2], 2'b00}});
            run_op(1'b0, f3, a, 32'h0, rd, dly, rdata, 7);
            e = sb.pop_front();
            checks++; if (obs_wb_data !== e.data || obs_wb_rd !== e.rd) begin failures++; $display("FAIL load_rand%0d f3=%b addr=%h: got rd=%0d data=%h want rd=%0d data=%h", i, f3, a, obs_wb_rd, obs_wb_data, e.rd, e.data); end
            checks++; if (obs_wb_cycle !== 3 + dly || obs_addr !== e.addr) begin failures++; $display("FAIL load_rand%0d_timing: got cycle=%0d addr=%h want cycle=%0d addr=%h", i, obs_wb_cycle, obs_addr, 3 + dly, e.addr); end
        end
    endtask

    task automatic test_store();
        exp_t e;
        logic [2:0]  f3s   [4] = '{3'b001, 3'b000, 3'b010, 3'b000};
        logic [31:0] addrs [4] = '{32'h102, 32'h101, 32'h204, 32'h203};
        logic [31:0] wds   [4] = '{32'h1234ABCD, 32'h000000A5, 32'hCAFEF00D, 32'h77665511};
        logic [31:0] exp_d [4] = '{32'hABCDABCD, 32'hA5A5A5A5, 32'hCAFEF00D, 32'h11111111};
        logic [3:0]  exp_s [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{1'b0, 5'd0, exp_d[i], 1'b0, 2'b00, exp_s[i], {addrs[i][31:2], 2'b00}});
            run_op(1'b1, f3s[i], addrs[i], wds[i], 5'd9, 0, 32'h0, 5);
            e = sb.pop_front();
            checks++; if (obs_strb !== e.strb || obs_wdata !== e.data || obs_addr !== e.addr) begin failures++; $display("FAIL store%0d_bus: got strb=%b data=%h addr=%h want strb=%b data=%h addr=%h", i, obs_strb, obs_wdata, obs_addr, e.strb, e.data, e.addr); end
            checks++; if (obs_we !== 1'b1 || obs_req_cnt !== 1) begin failures++; $display("FAIL store%0d_req: got we=%b req_cycles=%0d want we=1 req_cycles=1", i, obs_we, obs_req_cnt); end
            checks++; if (obs_wb_cnt !== 0 || obs_err_cnt !== 0 || obs_idle_cycle !== 2) begin failures++; $display("FAIL store%0d_done: got wb=%0d err=%0d idle_at=%0d want 0 0 2", i, obs_wb_cnt, obs_err_cnt, obs_idle_cycle); end
        end
    endtask

    task automatic test_errors();
        exp_t e;
        logic        sts   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s   [7] = '{3'b010, 3'b011, 3'b110, 3'b011, 3'b011, 3'b001, 3'b001};
        logic [31:0] addrs [7] = '{32'h101, 32'h100, 32'h0, 32'h0, 32'h101, 32'h103, 32'h101};
        logic [1:0]  codes [7] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        for (int i = 0; i < 7; i++) begin
            sb.push_back('{1'b0, 5'd0, 32'h0, 1'b1, codes[i], 4'b0000, 32'h0});
            run_op(sts[i], f3s[i], addrs[i], 32'h55555555, 5'd4, 0, 32'h12345678, 4);
            e = sb.pop_front();
            checks++; if (obs_err_cnt !== 1 || obs_err_cycle !== 1 || obs_code !== e.code) begin failures++; $display("FAIL err%0d: got pulses=%0d at=%0d code=%b want pulses=1 at=1 code=%b", i, obs_err_cnt, obs_err_cycle, obs_code, e.code); end
            checks++; if (obs_req_cnt !== 0 || obs_wb_cnt !== 0 || obs_idle_cycle !== 2) begin failures++; $display("FAIL err%0d_side: got req=%0d wb=%0d idle_at=%0d want 0 0 2", i, obs_req_cnt, obs_wb_cnt, obs_idle_cycle); end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int late_wb;
        sb.push_back('{1'b0, 5'd3, 32'h0, 1'b1, 2'b11, 4'b0000, 32'h100});
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd3, 1000, 32'h0, 10);
        e = sb.pop_front();
        checks++; if (obs_err_cnt !== 1 || obs_code !== e.code) begin failures++; $display("FAIL timeout_err: got pulses=%0d code=%b want 1 %b", obs_err_cnt, obs_code, e.code); end
        checks++; if (obs_req_cnt < 4 || obs_req_cnt > 5) begin failures++; $display("FAIL timeout_req_len: got %0d want 4..5", obs_req_cnt); end
        checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL timeout_idle: got req=%b busy=%b want 0 0", mem_req, busy); end
        late_wb = 0;
        mem_rvalid = 1'b1; mem_rdata = 32'hBADBAD00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (wb_en || busy) late_wb++;
        end
        mem_rvalid = 1'b0;
        checks++; if (late_wb !== 0) begin failures++; $display("FAIL timeout_late_rvalid: got %0d active cycles want 0", late_wb); end
    endtask

    task automatic test_reset_mid_op();
        int stray;
        op_valid = 1'b1; op_is_store = 1'b0; op_funct3 = 3'b010; op_addr = 32'h200; op_rd = 5'd6;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        mem_ready = mem_req;
        @(negedge clk);
        mem_ready = 1'b0;
        checks++; if (busy !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL midop_wait_r: got busy=%b req=%b want 1 0", busy, mem_req); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (op_ready !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midop_reset_idle: got ready=%b req=%b busy=%b want 1 0 0", op_ready, mem_req, busy); end
        stray = 0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0F0F0F0F;
        for (int k = 0; k < 3; k++) begin
            if (wb_en || err_valid) stray++;
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        checks++; if (stray !== 0) begin failures++; $display("FAIL midop_no_pulse: got %0d pulse cycles want 0", stray); end
    endtask

    task automatic test_rd_zero();
        exp_t e;
        sb.push_back('{1'b1, 5'd0, 32'h13572468, 1'b0, 2'b00, 4'b0000, 32'h300});
        run_op(1'b0, 3'b010, 32'h300, 32'h0, 5'd0, 0, 32'h13572468, 6);
        e = sb.pop_front();
        checks++; if (obs_req_cnt !== 1 || obs_addr !== e.addr) begin failures++; $display("FAIL rd0_access: got req=%0d addr=%h want 1 %h", obs_req_cnt, obs_addr, e.addr); end
        checks++; if (obs_wb_cnt !== int'(e.rd != 5'd0)) begin failures++; $display("FAIL rd0_wb_en: got %0d pulses want %0d", obs_wb_cnt, int'(e.rd != 5'd0)); end
        checks++; if (obs_idle_cycle !== 4) begin failures++; $display("FAIL rd0_through_wb: got idle at %0d want 4", obs_idle_cycle); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sb.push_back('{1'b1, 5'd10, 32'hFFFF8001, 1'b0, 2'b00, 4'b0000, 32'h400});
        sb.push_back('{1'b0, 5'd0, 32'h5A5A5A5A, 1'b0, 2'b00, 4'b0001, 32'h404});
        sb.push_back('{1'b1, 5'd11, 32'h0000BEEF, 1'b0, 2'b00, 4'b0000, 32'h408});
        run_op(1'b0, 3'b001, 32'h402, 32'h0, 5'd10, 0, 32'h80017777, 4);
        e = sb.pop_front();
        checks++; if (obs_ready_offer !== 1'b1 || obs_wb_data !== e.data || obs_wb_rd !== e.rd) begin failures++; $display("FAIL b2b_lh: got ready=%b rd=%0d data=%h want 1 %0d %h", obs_ready_offer, obs_wb_rd, obs_wb_data, e.rd, e.data); end
        run_op(1'b1, 3'b000, 32'h404, 32'h0000015A, 5'd0, 0, 32'h0, 2);
        e = sb.pop_front();
        checks++; if (obs_ready_offer !== 1'b1 || obs_wdata !== e.data || obs_strb !== e.strb || obs_addr !== e.addr) begin failures++; $display("FAIL b2b_sb: got ready=%b data=%h strb=%b addr=%h want 1 %h %b %h", obs_ready_offer, obs_wdata, obs_strb, obs_addr, e.data, e.strb, e.addr); end
        run_op(1'b0, 3'b101, 32'h408, 32'h0, 5'd11, 1, 32'h1234BEEF, 6);
        e = sb.pop_front();
        checks++; if (obs_ready_offer !== 1'b1 || obs_wb_data !== e.data || obs_wb_cycle !== 4) begin failures++; $display("FAIL b2b_lhu: got ready=%b data=%h cycle=%0d want 1 %h 4", obs_ready_offer, obs_wb_data, obs_wb_cycle, e.data); end
        checks++; if (obs_ready_bad !== 0) begin failures++; $display("FAIL b2b_busy_ready: got %0d bad cycles want 0", obs_ready_bad); end
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; op_is_store = 1'b0; op_funct3 = '0; op_addr = '0;
        op_wdata = '0; op_rd = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_errors();
        test_timeout();
        test_reset_mid_op();
        test_rd_zero();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
